cache_mem_responder: RTL
========================

// Module: cache_mem_responder
// PURPOSE
//  Memory-side responder for the cache's line interface (mem_read/mem_write/mem_addr/mem_rdata/mem_wdata/mem_ready).
//  Serves one 128-bit line transfer at a time, with a fixed, programmable latency.
//  Backed by a local line array; doubles as the synthesizable main-memory model in the CPU+cache test system.
// PARAMETERS
//  ADDR_W     28   line address width; matches cache mem_addr
//  LINE_W     128  line data width
//  IDX_W      8    log2 of stored lines; index = mem_addr[IDX_W-1:0]; upper bits ignored (aliasing is intended)
//  LATENCY    8    cycles from first request cycle to the mem_ready cycle; legal range 1..255
// PORTS
//  clk         in   1       single clock, all state updates on rising edge
//  proc_reset  in   1       asynchronous, active-high reset
//  mem_read    in   1       line read request; held high until the mem_ready cycle
//  mem_write   in   1       line write request; held high until the mem_ready cycle
//  mem_addr    in   ADDR_W  line address
//  mem_wdata   in   LINE_W  write line data
//  mem_rdata   out  LINE_W  read line data; valid in the mem_ready cycle
//  mem_ready   out  1       one-cycle completion pulse
//  proto_err   out  1       sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset (async, proc_reset=1): state=IDLE, cnt=0, mem_ready=0, mem_rdata=0, proto_err=0.
//    Line array contents are not cleared.
//  FSM states: IDLE, BUSY, READY.
//  IDLE:
//    - (mem_read|mem_write)=1 at an edge -> accept the request.
//    - On accept, latch: op, idx = mem_addr[IDX_W-1:0], and mem_wdata (if write).
//    - Then go to READY if LATENCY==1; otherwise go to BUSY with cnt = LATENCY-2.
//  BUSY:
//    - Request dropped (both lows) -> abort to IDLE. No mem_ready, no array write.
//    - Else if cnt==0 -> READY. For a read, mem_rdata <= array[idx] on this edge.
//    - Else cnt <= cnt-1.
//  READY:
//    - mem_ready=1 for exactly one cycle; next state is IDLE unconditionally.
//    - For a write, array[idx] <= latched wdata on the READY->IDLE edge.
//  Timing: request first high in cycle t -> mem_ready high in cycle t+LATENCY, low in t+LATENCY+1.
//  mem_ready and mem_rdata are registered outputs, with no combinational input->output paths.
//  mem_rdata holds its last read value outside READY. Writes do not change it.
//  Inputs are sampled only on accept:
//    - mem_addr/mem_wdata changes during BUSY are ignored.
//    - op flips are ignored, but a full drop aborts.
//  The requester drops its request combinationally in the ready cycle. The responder ignores its inputs in READY.
//  A new request may be accepted in the cycle after READY (e.g. write-back immediately followed by allocate).
//  Both mem_read and mem_write high at accept:
//    - The request is served as a write.
//    - proto_err <= 1.
//  Read-after-write to the same idx (back-to-back): the read returns the new data.
//    The write commits before the read's array access.
//  Reset asserted mid-transfer: immediate IDLE, mem_ready=0, pending write discarded.
// STRUCTURE
//  cache_mem_pkg holds the shared constants and types:
//    - ADDR_W and LINE_W (shared with the cache).
//    - state enum {IDLE, BUSY, READY}.
//  Sub-module mem_line_array: 2^IDX_W x LINE_W, 1 sync write port, 1 read port.
//    The read port is registered by the parent.
//  Top level: FSM, 8-bit latency counter, request latches, proto_err flag.
// TESTING
//  1. Reset, LATENCY=8: write 0xDEAD..BEEF to addr 0x0000005, read it back.
//     -> Each mem_ready is exactly 8 cycles after its request and 1 cycle wide; rdata matches.
//  2. Write-back to 0x12 then allocate read of 0x34 on the next cycle.
//     -> Two ready pulses, 8 cycles apart (gap measured from the 2nd request); read returns preloaded line.
//  3. Read with mem_read dropped at cycle 3 of BUSY, then a new read.
//     -> No ready for the first; the second completes normally; array unchanged.
//  4. mem_read & mem_write both high, addr 0x7, wdata 0xA5..A5.
//     -> Served as a write; proto_err=1 and stays 1; readback gives 0xA5..A5.
//  5. LATENCY=1: read request at cycle t.
//     -> mem_ready at t+1. Addr 0x100 with IDX_W=8 aliases to index 0x00.
//  6. proc_reset pulsed mid-BUSY of a write to 0x9 (not aligned to clk).
//     -> mem_ready stays 0; later readback of 0x9 returns the old data.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Constants and types shared by the cache line interface and the memory responder.
package cache_mem_pkg;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        READY
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: one synchronous write port and one unregistered read port.
// The read result is captured into a register by the instantiating block.
module mem_line_array #(
    parameter int IDX_W  = 8,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache line interface: one line transfer at a
// time, completing a fixed LATENCY cycles after the request first appears.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int IDX_W   = 8,
    parameter int LATENCY = 8
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err
);

    // Accept edge already consumes one cycle and READY another.
    localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    state_e            state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    op_e               op_reg, op_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [LINE_W-1:0] wdata_reg, wdata_next;
    logic [LINE_W-1:0] rdata_reg;
    logic              ready_reg, ready_next;
    logic              err_reg, err_next;
    logic              rdata_load;
    logic              mem_we;
    logic              req;
    logic [IDX_W-1:0]  rd_idx;
    logic [LINE_W-1:0] array_rdata;

    // Address bits above the index alias onto the same line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[ADDR_W-1:IDX_W];

    assign req = mem_read | mem_write;

    // With LATENCY==1 the read happens on the accept edge, so the live address is used.
    assign rd_idx = (state_reg == IDLE) ? mem_addr[IDX_W-1:0] : idx_reg;

    mem_line_array #(
        .IDX_W  (IDX_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_reg),
        .wdata (wdata_reg),
        .raddr (rd_idx),
        .rdata (array_rdata)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        idx_next   = idx_reg;
        wdata_next = wdata_reg;
        err_next   = err_reg;
        ready_next = 1'b0;
        rdata_load = 1'b0;
        mem_we     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    op_next  = mem_write ? OP_WRITE : OP_READ;
                    idx_next = mem_addr[IDX_W-1:0];
                    if (mem_write) begin
                        wdata_next = mem_wdata;
                    end
                    if (mem_read && mem_write) begin
                        err_next = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_next = READY;
                        ready_next = 1'b1;
                        rdata_load = !mem_write;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt_reg == 8'd0) begin
                    state_next = READY;
                    ready_next = 1'b1;
                    rdata_load = (op_reg == OP_READ);
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            READY: begin
                state_next = IDLE;
                mem_we     = (op_reg == OP_WRITE);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            op_reg    <= OP_READ;
            idx_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            idx_reg   <= idx_next;
            wdata_reg <= wdata_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
            if (rdata_load) begin
                rdata_reg <= array_rdata;
            end
        end
    end

    assign mem_rdata = rdata_reg;
    assign mem_ready = ready_reg;
    assign proto_err = err_reg;

endmodule
